fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that owns the architectural program counter. It drives pc_current to the downstream branch unit and loads that unit's pc_next when execute commits an instruction. Between commits it fetches one instruction from instruction memory over a req/ack handshake and presents it to decode with valid/ready. Fetch is non-speculative: exactly one instruction is in flight between PC updates.

Parameters:
PC_WIDTH, 16, width of PC and instruction-memory address
INSTR_WIDTH, 16, instruction word width
RESET_PC, 16'h0000, PC value after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pc_current  output  PC_WIDTH  architectural PC, to branch unit
pc_next  input  PC_WIDTH  next PC, from branch unit
pc_commit  input  1  execute retired the held instruction; load pc_next
imem_req  output  1  memory request, held until imem_ack
imem_addr  output  PC_WIDTH  request address (= pc_current)
imem_ack  input  1  read data valid this cycle
imem_rdata  input  INSTR_WIDTH  instruction word
instr_valid  output  1  instr_out/instr_pc valid to decode
instr_ready  input  1  decode accepts
instr_out  output  INSTR_WIDTH  fetched instruction
instr_pc  output  PC_WIDTH  address of instr_out
halt  input  1  level; suppresses new requests while high

Behaviour:
- Reset (async, immediate): pc_current=RESET_PC; state=FETCH; imem_req=0; instr_valid=0; instr_out=0; instr_pc=RESET_PC.
- FSM states: FETCH, WAIT_MEM, HOLD, WAIT_PC.
- FETCH: if !halt, assert imem_req and go to WAIT_MEM next cycle. imem_req is registered, so it rises one cycle after entering FETCH.
- WAIT_MEM: imem_req=1 and imem_addr=pc_current held stable. On imem_ack: capture imem_rdata into instr_out and pc_current into instr_pc, deassert imem_req and instr_valid=1 in the same edge, then go to HOLD. An ack in the first request cycle is legal.
- HOLD: instr_valid=1 and payload stable until instr_ready; on handshake instr_valid=0 and the FSM goes to WAIT_PC.
- WAIT_PC: on pc_commit, pc_current<=pc_next and go to FETCH. Minimum loop is ack-to-next-req = 3 cycles with zero-wait decode/commit.
- pc_commit outside WAIT_PC is ignored. It is a protocol error; flag it with an assertion in simulation only.
- halt is sampled only in FETCH. A halt raised during WAIT_MEM does not cancel the outstanding request.
- imem_ack outside WAIT_MEM is ignored.
- Wrap-around: pc_current is a plain register. pc_next=16'hFFFF+1 wraps to 0 in the branch unit, and fetch just loads the value it is given.
- Reset mid-transaction drops the request immediately. A late imem_ack after reset lands in FETCH and is ignored.
- imem_addr is combinationally pc_current. All other outputs are registered.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0].
  - perf_fetched increments on each imem_ack accepted in WAIT_MEM.
  - perf_stall increments on each cycle spent in WAIT_MEM without an ack, or in HOLD without instr_ready.
  - Both counters saturate at all-ones and are cleared by rst.
- Undefined: the ports and logic are absent and the block's behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_WIDTH and INSTR_WIDTH defaults;
  - fetch_state_t enum {FETCH, WAIT_MEM, HOLD, WAIT_PC};
  - the branch opcode constants JMP=4'b1001, BRZ=4'b1010, BRNZ=4'b1011, BRNS=4'b1100, reused by decode and the bench.
- One natural sub-module, fetch_perf_counters, instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset then release, imem_ack one cycle after imem_req → imem_addr=0x0000, instr_valid rises with instr_out=imem_rdata and instr_pc=0x0000; pc_current stays 0x0000 until commit.
- Hold instr_ready low 5 cycles with instr_out=0x9003 → instr_valid and payload stable all 5 cycles; no new imem_req; pc_commit with pc_next=0x0003 then loads pc_current=0x0003 and the next request is to 0x0003.
- Delay imem_ack 4 cycles → imem_req and imem_addr stable throughout; exactly one capture (with FETCH_PERF_EN: perf_fetched=1, perf_stall=3).
- pc_current=0xFFFF, commit with pc_next=0x0000 → next imem_addr=0x0000; also assert pc_commit during HOLD → ignored and pc_current unchanged.
- halt high in FETCH for 3 cycles → no imem_req; request issues the cycle after halt drops.
- Assert rst in WAIT_MEM with a later stray imem_ack → outputs return to reset values immediately, the ack is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for fetch, decode and the bench
package cpu_pkg;

  localparam int CPU_PC_WIDTH    = 16;
  localparam int CPU_INSTR_WIDTH = 16;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_MEM = 2'd1,
    HOLD     = 2'd2,
    WAIT_PC  = 2'd3
  } fetch_state_t;

  // Branch opcodes live in the top nibble of the instruction word
  localparam logic [3:0] JMP  = 4'b1001;
  localparam logic [3:0] BRZ  = 4'b1010;
  localparam logic [3:0] BRNZ = 4'b1011;
  localparam logic [3:0] BRNS = 4'b1100;

endpackage

// File: rtl/fetch_perf_counters.sv
// rtl/fetch_perf_counters.sv - saturating fetch/stall event counters for fetch_unit
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_inc && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (stall_inc && (perf_stall != '1))   perf_stall   <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - non-speculative instruction fetch stage owning the architectural PC
// Optional FETCH_PERF_EN adds perf_fetched/perf_stall counter outputs.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH    = CPU_PC_WIDTH,
  parameter int                  INSTR_WIDTH = CPU_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    pc_current,
  input  logic [PC_WIDTH-1:0]    pc_next,
  input  logic                   pc_commit,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   halt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall
`endif
);

  fetch_state_t state, state_next;
  logic         req_next;
  logic         valid_next;
  logic         capture;
  logic         pc_load;

  assign imem_addr = pc_current;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_next   = imem_req;
    valid_next = instr_valid;
    capture    = 1'b0;
    pc_load    = 1'b0;
    case (state)
      FETCH: begin
        if (!halt) begin
          req_next   = 1'b1;
          state_next = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (imem_ack) begin
          req_next   = 1'b0;
          valid_next = 1'b1;
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          valid_next = 1'b0;
          state_next = WAIT_PC;
        end
      end
      WAIT_PC: begin
        if (pc_commit) begin
          pc_load    = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        req_next   = 1'b0;
        valid_next = 1'b0;
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_current  <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= RESET_PC;
    end else begin
      imem_req    <= req_next;
      instr_valid <= valid_next;
      if (pc_load) pc_current <= pc_next;
      if (capture) begin
        instr_out <= imem_rdata;
        instr_pc  <= pc_current;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_inc;
  assign stall_inc = ((state == WAIT_MEM) && !imem_ack) ||
                     ((state == HOLD) && !instr_ready);

  fetch_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .fetch_inc    (capture),
    .stall_inc    (stall_inc),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

`ifndef SYNTHESIS
  // A commit while an instruction is still outstanding is dropped by the FSM
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(pc_commit && (state != WAIT_PC)))
        else $warning("fetch_unit: pc_commit outside WAIT_PC ignored");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_current;
  logic [15:0] pc_next;
  logic        pc_commit;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        halt;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_current  (pc_current),
    .pc_next     (pc_next),
    .pc_commit   (pc_commit),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .halt        (halt)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] jmp_word;

  initial begin
    jmp_word    = {JMP, 12'h003};
    rst         = 1'b1;
    pc_next     = '0;
    pc_commit   = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    halt        = 1'b0;
    #2;
    chk("rst_pc", pc_current, 16'h0000);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_iout", instr_out, 16'h0000);
    chk("rst_ipc", instr_pc, 16'h0000);
    step();
    step();
    rst = 1'b0;

    // First fetch from RESET_PC, ack in the first request cycle
    step();
    chk("f0_req", imem_req, 1'b1);
    chk("f0_addr", imem_addr, 16'h0000);
    imem_ack   = 1'b1;
    imem_rdata = jmp_word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'h5555;
    chk("f0_valid", instr_valid, 1'b1);
    chk("f0_iout", instr_out, 16'h9003);
    chk("f0_ipc", instr_pc, 16'h0000);
    chk("f0_req_drop", imem_req, 1'b0);
    chk("f0_pc", pc_current, 16'h0000);

    // Decode backpressure for 5 cycles; a commit in HOLD must be ignored
    for (int i = 0; i < 5; i++) begin
      pc_commit = (i == 2);
      pc_next   = 16'h1234;
      step();
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_iout", instr_out, 16'h9003);
      chk("hold_req", imem_req, 1'b0);
      chk("hold_pc", pc_current, 16'h0000);
    end
    pc_commit   = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("hs_valid", instr_valid, 1'b0);
    pc_commit = 1'b1;
    pc_next   = 16'h0003;
    step();
    pc_commit = 1'b0;
    chk("c1_pc", pc_current, 16'h0003);
    chk("c1_req", imem_req, 1'b0);
    step();
    chk("f1_req", imem_req, 1'b1);
    chk("f1_addr", imem_addr, 16'h0003);

    // Slow memory: ack on the fourth request cycle
    for (int i = 0; i < 3; i++) begin
      step();
      chk("slow_req", imem_req, 1'b1);
      chk("slow_addr", imem_addr, 16'h0003);
      chk("slow_valid", instr_valid, 1'b0);
    end
    imem_ack   = 1'b1;
    imem_rdata = 16'hA105;
    step();
    chk("f1_valid", instr_valid, 1'b1);
    chk("f1_iout", instr_out, 16'hA105);
    chk("f1_ipc", instr_pc, 16'h0003);
    chk("f1_req_drop", imem_req, 1'b0);
    // Stray ack in HOLD must not overwrite the payload
    imem_rdata  = 16'hDEAD;
    instr_ready = 1'b1;
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    chk("stray_iout", instr_out, 16'hA105);
    chk("stray_valid", instr_valid, 1'b0);

    // Jump to the top of the address space, then wrap to 0
    pc_commit = 1'b1;
    pc_next   = 16'hFFFF;
    step();
    pc_commit = 1'b0;
    chk("c2_pc", pc_current, 16'hFFFF);
    step();
    chk("f2_addr", imem_addr, 16'hFFFF);
    imem_ack   = 1'b1;
    imem_rdata = 16'hB200;
    step();
    imem_ack    = 1'b0;
    chk("f2_ipc", instr_pc, 16'hFFFF);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    pc_commit = 1'b1;
    pc_next   = 16'h0000;
    step();
    pc_commit = 1'b0;
    chk("wrap_pc", pc_current, 16'h0000);

    // Halt held in FETCH for 3 cycles
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_req", imem_req, 1'b0);
    end
    halt = 1'b0;
    step();
    chk("unhalt_req", imem_req, 1'b1);
    chk("unhalt_addr", imem_addr, 16'h0000);
    imem_ack   = 1'b1;
    imem_rdata = 16'h1111;
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    pc_commit = 1'b1;
    pc_next   = 16'h0040;
    step();
    pc_commit = 1'b0;
    step();
    chk("f4_req", imem_req, 1'b1);
    chk("f4_addr", imem_addr, 16'h0040);

    // Reset while the request is outstanding
    rst = 1'b1;
    #1;
    chk("mrst_pc", pc_current, 16'h0000);
    chk("mrst_req", imem_req, 1'b0);
    chk("mrst_valid", instr_valid, 1'b0);
    chk("mrst_iout", instr_out, 16'h0000);
    chk("mrst_ipc", instr_pc, 16'h0000);
    step();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    chk("late_valid", instr_valid, 1'b0);
    chk("late_iout", instr_out, 16'h0000);
    chk("late_req", imem_req, 1'b1);
    chk("late_addr", imem_addr, 16'h0000);
    imem_ack   = 1'b1;
    imem_rdata = 16'h2222;
    step();
    imem_ack = 1'b0;
    chk("f5_valid", instr_valid, 1'b1);
    chk("f5_iout", instr_out, 16'h2222);
    chk("f5_ipc", instr_pc, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
